mobility_accum: RTL and testbench

//  Downstream consumer of the 5-stage popcount pipeline in the evaluator.
//  - Upstream drives a bitboard into popcount and, in the same cycle, a tag
//    (side, piece, last) into this block.
//  - Delays each tag POP_LATENCY cycles so it lines up with popcount.population.
//  - Multiplies each population by a per-piece weight and accumulates the

---
 rtl/mobility_accum.sv | 137 +++++++++++++
 tb/tb_mobility_accum.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mobility_accum.sv
// rtl/mobility_accum.sv - weighted mobility accumulator aligned to the popcount pipeline
// Optional saturation of the accumulator: MOBILITY_SAT_EN.
module mobility_accum #(
  parameter int         POP_LATENCY = 5,
  parameter int         ACC_W       = 16,
  parameter logic [7:0] W_PAWN      = 8'd1,
  parameter logic [7:0] W_KNIGHT    = 8'd4,
  parameter logic [7:0] W_BISHOP    = 8'd3,
  parameter logic [7:0] W_ROOK      = 8'd2,
  parameter logic [7:0] W_QUEEN     = 8'd1,
  parameter logic [7:0] W_KING      = 8'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic                    in_side,
  input  logic [2:0]              in_piece,
  input  logic                    in_last,
  input  logic [5:0]              population,
  output logic                    busy,
  output logic signed [ACC_W-1:0] score,
  output logic                    score_valid
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [POP_LATENCY-1:0]       pipe_valid, pipe_side, pipe_last;
  logic [POP_LATENCY-1:0][2:0]  pipe_piece;
  logic                         restart, tag_valid;
  logic                         out_valid, out_side, out_last;
  logic [2:0]                   out_piece;
  logic [7:0]                   weight;
  logic [13:0]                  prod;
  logic                         acc_upd, finish;
  logic signed [ACC_W-1:0]      acc, acc_step;

  // start outside DONE aborts whatever is in flight
  assign restart   = start && (state != DONE);
  assign tag_valid = in_valid && (state == ACCUM) && !start;

  assign out_valid = pipe_valid[POP_LATENCY-1];
  assign out_side  = pipe_side[POP_LATENCY-1];
  assign out_last  = pipe_last[POP_LATENCY-1];
  assign out_piece = pipe_piece[POP_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_side  <= '0;
      pipe_last  <= '0;
      pipe_piece <= '0;
    end else begin
      pipe_valid <= restart ? '0 : {pipe_valid[POP_LATENCY-2:0], tag_valid};
      pipe_side  <= {pipe_side[POP_LATENCY-2:0], in_side};
      pipe_last  <= {pipe_last[POP_LATENCY-2:0], in_last};
      pipe_piece <= {pipe_piece[POP_LATENCY-2:0], in_piece};
    end
  end

  always_comb begin
    weight = 8'd0;
    case (out_piece)
      3'd0:    weight = W_PAWN;
      3'd1:    weight = W_KNIGHT;
      3'd2:    weight = W_BISHOP;
      3'd3:    weight = W_ROOK;
      3'd4:    weight = W_QUEEN;
      3'd5:    weight = W_KING;
      default: weight = 8'd0;
    endcase
  end

  assign prod    = {8'd0, population} * {6'd0, weight};
  assign acc_upd = out_valid && ((state == ACCUM) || (state == DRAIN));
  assign finish  = (state == DRAIN) && !start && acc_upd && out_last;

`ifdef MOBILITY_SAT_EN
  localparam int EW = ((ACC_W > 14) ? ACC_W : 14) + 2;
  localparam logic signed [EW-1:0] SAT_MAX = EW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [EW-1:0] acc_ext, prod_ext, sum;

  assign acc_ext  = EW'(acc);
  assign prod_ext = EW'(prod);
  assign sum      = out_side ? (acc_ext - prod_ext) : (acc_ext + prod_ext);

  always_comb begin
    acc_step = sum[ACC_W-1:0];
    if (sum > SAT_MAX)      acc_step = SAT_MAX[ACC_W-1:0];
    else if (sum < SAT_MIN) acc_step = SAT_MIN[ACC_W-1:0];
  end
`else
  assign acc_step = out_side ? (acc - ACC_W'(prod)) : (acc + ACC_W'(prod));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      score <= '0;
    end else begin
      if (restart)      acc <= '0;
      else if (acc_upd) acc <= acc_step;
      // score is captured as DONE is entered so it is valid with the pulse
      if (finish)       score <= acc_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = ACCUM;
      ACCUM: begin
        if (start)                     state_next = ACCUM;
        else if (in_valid && in_last)  state_next = DRAIN;
      end
      DRAIN: begin
        if (start)       state_next = ACCUM;
        else if (finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign score_valid = (state == DONE);

endmodule

// File: tb/tb_mobility_accum.sv
// tb/tb_mobility_accum.sv - scoreboard bench for mobility_accum (16-bit and 8-bit accumulators)
module tb_mobility_accum;

  logic clk = 1'b0;
  logic reset, start, in_valid, in_side, in_last;
  logic [2:0] in_piece;
  logic [5:0] in_pop, population;
  logic busy16, sv16, busy8, sv8;
  logic signed [15:0] score16;
  logic signed [7:0]  score8;
  logic [4:0][5:0] pop_sr;
  int cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int e16; int e8; int at; } exp_t;
  exp_t sb[$];
  int m16, m8;
  int wt[8] = '{1, 4, 3, 2, 1, 0, 0, 0};

  mobility_accum dut16 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_side(in_side),
    .in_piece(in_piece), .in_last(in_last), .population(population),
    .busy(busy16), .score(score16), .score_valid(sv16)
  );

  mobility_accum #(.ACC_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_side(in_side),
    .in_piece(in_piece), .in_last(in_last), .population(population),
    .busy(busy8), .score(score8), .score_valid(sv8)
  );

  always #5 clk = ~clk;

  // stand-in for the 5-stage popcount: population follows the driven value by 5 cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) pop_sr <= '0;
    else       pop_sr <= {pop_sr[3:0], in_pop};
  end
  assign population = pop_sr[4];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fold(input int a, input int d, input int w);
    int r, hi, lo;
    r  = a + d;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
`ifdef MOBILITY_SAT_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    r = r & ((1 << w) - 1);
    if (r > hi) r = r - (1 << w);
`endif
    return r;
  endfunction

  task automatic step(input logic s, input logic v, input logic sd, input logic [2:0] pc,
                      input logic lst, input logic [5:0] pop);
    start = s; in_valid = v; in_side = sd; in_piece = pc; in_last = lst; in_pop = pop;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 6'd0);
  endtask

  task automatic begin_eval();
    m16 = 0; m8 = 0;
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 6'd0);
  endtask

  task automatic ent(input logic sd, input logic [2:0] pc, input int pop, input logic lst);
    exp_t e;
    int d;
    d = wt[pc] * pop;
    if (sd) d = -d;
    m16 = fold(m16, d, 16);
    m8  = fold(m8, d, 8);
    if (lst) begin
      e.e16 = m16; e.e8 = m8; e.at = cyc + 6;
      sb.push_back(e);
    end
    step(1'b0, 1'b1, sd, pc, lst, 6'(pop));
  endtask

  task automatic wait_done();
    exp_t e;
    int k;
    e = sb.pop_front();
    k = 0;
    while (!sv16 && k < 20) begin
      idle(1);
      k++;
    end
    chk("sv16_seen", sv16, 1);
    chk("latency", cyc, e.at);
    chk("score16", score16, e.e16);
    chk("score8", score8, e.e8);
    chk("sv8", sv8, 1);
    chk("busy_at_pulse", busy16, 1);
    idle(1);
    chk("sv16_one_cycle", sv16, 0);
    chk("busy_after", busy16, 0);
    chk("score16_hold", score16, e.e16);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_side = 1'b0; in_piece = 3'd0; in_last = 1'b0; in_pop = 6'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", busy16, 0);
    chk("rst_sv", sv16, 0);
    chk("rst_score16", score16, 0);
    chk("rst_score8", score8, 0);
    reset = 1'b0;
    idle(2);

    // white knight 8 minus black bishop 4
    begin_eval();
    ent(1'b0, 3'd1, 8, 1'b0);
    ent(1'b1, 3'd2, 4, 1'b1);
    wait_done();

    // single-entry evaluation
    begin_eval();
    ent(1'b0, 3'd0, 63, 1'b1);
    wait_done();

    // restart with entries in flight; in_valid alongside start is dropped
    begin_eval();
    ent(1'b0, 3'd4, 30, 1'b0);
    ent(1'b0, 3'd1, 10, 1'b0);
    m16 = 0; m8 = 0;
    step(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 6'd40);
    chk("restart_score_hold", score16, 63);
    chk("restart_busy", busy16, 1);
    ent(1'b1, 3'd3, 5, 1'b1);
    wait_done();

    // stray entries while IDLE and DRAIN
    step(1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 6'd33);
    step(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 6'd33);
    chk("stray_idle_busy", busy16, 0);
    begin_eval();
    ent(1'b0, 3'd2, 7, 1'b0);
    ent(1'b1, 3'd1, 2, 1'b1);
    step(1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 6'd50);
    step(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 6'd9);
    wait_done();

    // 8-bit instance overflows: saturates or wraps
    begin_eval();
    ent(1'b0, 3'd1, 20, 1'b0);
    ent(1'b0, 3'd1, 20, 1'b0);
    ent(1'b0, 3'd1, 20, 1'b1);
    wait_done();

    // reset mid-DRAIN
    begin_eval();
    ent(1'b0, 3'd1, 8, 1'b1);
    void'(sb.pop_back());
    idle(2);
    chk("drain_busy", busy16, 1);
    reset = 1'b1;
    idle(1);
    chk("rstd_busy", busy16, 0);
    chk("rstd_sv", sv16, 0);
    chk("rstd_score16", score16, 0);
    chk("rstd_score8", score8, 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (sv16 || sv8 || busy16) seen++;
    end
    chk("no_late_pulse", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
